// File: rtl/sr_pq_ctrl_if.sv
// sr_pq_ctrl: shared key-value type and the controller's bus interface.
// Enqueue/dequeue handshakes plus the control lines to the shift-register PQ array.
package sr_pq_pkg;
  typedef struct packed {
    logic [7:0] key;
    logic [7:0] val;
  } kv_t;

  localparam kv_t KV_EMPTY = '{key: 8'hFF, val: 8'hFF};
endpackage

interface sr_pq_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int NREQ  = 4
);
  import sr_pq_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic                flush;
  logic [NREQ-1:0]     enq_valid;
  kv_t  [NREQ-1:0]     enq_kv;
  logic [NREQ-1:0]     enq_ready;
  logic                deq_valid;
  logic                deq_ready;
  kv_t                 deq_kv;
  kv_t                 pq_head;
  logic                pq_rst;
  logic                pq_enq;
  logic                pq_deq;
  logic                pq_replace;
  kv_t                 pq_kvi;
  logic [CW-1:0]       count;
  logic                full;
  logic                empty;

  modport slave (
    input  flush, enq_valid, enq_kv, deq_ready, pq_head,
    output enq_ready, deq_valid, deq_kv, pq_rst, pq_enq,
           pq_deq, pq_replace, pq_kvi, count, full, empty
  );

  modport master (
    output flush, enq_valid, enq_kv, deq_ready, pq_head,
    input  enq_ready, deq_valid, deq_kv, pq_rst, pq_enq,
           pq_deq, pq_replace, pq_kvi, count, full, empty
  );
endinterface

// File: rtl/sr_pq_ctrl.sv
// sr_pq_ctrl: round-robin enqueue arbiter and occupancy tracker
// driving the strobes of an attached shift-register priority queue.
module sr_pq_ctrl
  import sr_pq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NREQ  = 4
) (
  input  logic         clk,
  input  logic         rst,
  sr_pq_ctrl_if.slave  pq_if
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(NREQ);

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            full_w, empty_w;
  logic            deq_xfer, enq_xfer, grant_ok;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gidx;
  logic [PW-1:0]   jx;
  int              j;

  assign full_w  = !rst && (count_q == CW'(DEPTH));
  assign empty_w = rst || (count_q == '0);

  assign deq_xfer = !rst && !pq_if.flush && !empty_w
                 && pq_if.deq_ready;
  assign grant_ok = !rst && !pq_if.flush
                 && (!full_w || deq_xfer);

  // round-robin search starting at rr_ptr, first valid requester wins
  always_comb begin
    gnt      = '0;
    gidx     = '0;
    enq_xfer = 1'b0;
    j        = 0;
    jx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NREQ) j = j - NREQ;
      jx = PW'(j);
      if (grant_ok && !enq_xfer && pq_if.enq_valid[jx]) begin
        enq_xfer = 1'b1;
        gidx     = jx;
        gnt[jx]  = 1'b1;
      end
    end
  end

  assign pq_if.enq_ready  = gnt;
  assign pq_if.pq_rst     = rst || pq_if.flush;
  assign pq_if.pq_enq     = enq_xfer && !deq_xfer;
  assign pq_if.pq_deq     = deq_xfer && !enq_xfer;
  assign pq_if.pq_replace = enq_xfer && deq_xfer;
  assign pq_if.pq_kvi     = enq_xfer ? pq_if.enq_kv[gidx]
                                     : KV_EMPTY;
  assign pq_if.deq_valid  = !empty_w;
  assign pq_if.deq_kv     = pq_if.pq_head;
  assign pq_if.count      = rst ? '0 : count_q;
  assign pq_if.full       = full_w;
  assign pq_if.empty      = empty_w;

  // next occupancy and round-robin pointer
  always_comb begin
    count_d  = count_q;
    rr_ptr_d = rr_ptr_q;
    if (enq_xfer && !deq_xfer)
      count_d = count_q + CW'(1);
    else if (deq_xfer && !enq_xfer)
      count_d = count_q - CW'(1);
    if (enq_xfer)
      rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0
                                         : gidx + PW'(1);
    if (pq_if.flush)
      count_d = '0;
  end

  // state registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  a_cnt_max: assert property (
    @(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
  a_no_ovf: assert property (
    @(posedge clk) disable iff (rst) !(pq_if.pq_enq && full_w));
  a_no_udf: assert property (
    @(posedge clk) disable iff (rst) !(pq_if.pq_deq && empty_w));

endmodule

// File: tb/tb_sr_pq_ctrl.sv
// tb_sr_pq_ctrl: random and directed stimulus against a sorted-queue
// model; dequeued heads are checked by a separate scoreboard monitor.
module tb_sr_pq_ctrl;
  import sr_pq_pkg::*;

  localparam int DEPTH = 8;
  localparam int NREQ  = 4;

  typedef kv_t kv_q_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sr_pq_ctrl_if #(.DEPTH(DEPTH), .NREQ(NREQ)) ifc ();

  sr_pq_ctrl #(.DEPTH(DEPTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst   (rst),
    .pq_if (ifc)
  );

  int checks = 0;
  int errors = 0;

  kv_q_t arr_q;
  kv_t   arr_head;
  kv_q_t ref_q;
  int    ref_rr;
  kv_q_t sb;

  assign ifc.pq_head = arr_head;

  // priority insert: smaller key first, ties keep arrival order
  function automatic kv_q_t ins(kv_q_t q, kv_t kv);
    int p = q.size();
    for (int i = 0; i < q.size(); i++)
      if (kv.key < q[i].key) begin
        p = i;
        break;
      end
    q.insert(p, kv);
    return q;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural shift-register PQ array reacting to controller strobes
  initial begin
    arr_head = KV_EMPTY;
    forever begin
      @(posedge clk);
      if (ifc.pq_rst)
        arr_q.delete();
      else if (ifc.pq_replace) begin
        if (arr_q.size() > 0) void'(arr_q.pop_front());
        arr_q = ins(arr_q, ifc.pq_kvi);
      end else if (ifc.pq_enq)
        arr_q = ins(arr_q, ifc.pq_kvi);
      else if (ifc.pq_deq && arr_q.size() > 0)
        void'(arr_q.pop_front());
      arr_head = (arr_q.size() > 0) ? arr_q[0] : KV_EMPTY;
    end
  end

  // scoreboard monitor: every dequeue transfer must match the model head
  initial begin
    kv_t e;
    forever begin
      @(negedge clk);
      #2;
      if (ifc.deq_valid && ifc.deq_ready && !rst && !ifc.flush) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL deq_unexpected: got %0h expected none",
                   ifc.deq_kv);
        end else begin
          e = sb.pop_front();
          chk("deq_kv", 32'(ifc.deq_kv), 32'(e));
        end
      end
    end
  end

  task automatic step(input logic r, input logic fl,
                      input logic [NREQ-1:0] ev,
                      input logic dr, input int k);
    kv_t kv[NREQ];
    int  n, g;
    bit  dx;
    logic [NREQ-1:0] er;
    kv_t ekvi;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      kv[i].key = (k >= 0) ? 8'(k) : 8'($urandom_range(0, 254));
      kv[i].val = 8'($urandom_range(0, 255));
    end
    rst = r;
    ifc.flush = fl;
    ifc.enq_valid = ev;
    ifc.deq_ready = dr;
    for (int i = 0; i < NREQ; i++) ifc.enq_kv[i] = kv[i];
    #1;
    n  = r ? 0 : ref_q.size();
    dx = !r && !fl && n > 0 && dr;
    g  = -1;
    if (!r && !fl && (n < DEPTH || dx))
      for (int i = 0; i < NREQ; i++)
        if (ev[(ref_rr + i) % NREQ]) begin
          g = (ref_rr + i) % NREQ;
          break;
        end
    er   = (g >= 0) ? NREQ'(1 << g) : '0;
    ekvi = (g >= 0) ? kv[g] : KV_EMPTY;
    chk("enq_ready", 32'(ifc.enq_ready), 32'(er));
    chk("pq_rst", 32'(ifc.pq_rst), 32'(r || fl));
    chk("pq_enq", 32'(ifc.pq_enq), 32'(g >= 0 && !dx));
    chk("pq_deq", 32'(ifc.pq_deq), 32'(g < 0 && dx));
    chk("pq_replace", 32'(ifc.pq_replace), 32'(g >= 0 && dx));
    chk("pq_kvi", 32'(ifc.pq_kvi), 32'(ekvi));
    chk("count", 32'(ifc.count), 32'(n));
    chk("full", 32'(ifc.full), 32'(n == DEPTH));
    chk("empty", 32'(ifc.empty), 32'(n == 0));
    chk("deq_valid", 32'(ifc.deq_valid), 32'(n != 0));
    if (dx) sb.push_back(ref_q[0]);
    if (r) begin
      ref_q.delete();
      ref_rr = 0;
    end else if (fl)
      ref_q.delete();
    else begin
      if (dx) void'(ref_q.pop_front());
      if (g >= 0) begin
        ref_q  = ins(ref_q, kv[g]);
        ref_rr = (g + 1) % NREQ;
      end
    end
  endtask

  initial begin
    ref_rr = 0;
    rst = 1'b1;
    ifc.flush = 1'b0;
    ifc.enq_valid = '0;
    ifc.deq_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) ifc.enq_kv[i] = KV_EMPTY;
    repeat (2) @(posedge clk);

    step(1, 0, 4'b1111, 1, -1);
    step(1, 1, 4'b1111, 1, -1);

    repeat (4) step(0, 0, 4'b1111, 0, -1);
    step(0, 0, 4'b0000, 0, -1);
    repeat (5) step(0, 0, 4'b0000, 1, -1);

    step(0, 0, 4'b0001, 0, 5);
    step(0, 0, 4'b0001, 0, 3);
    step(0, 0, 4'b0001, 0, 9);
    repeat (3) step(0, 0, 4'b0000, 1, -1);
    step(0, 0, 4'b0000, 0, -1);

    repeat (8) step(0, 0, 4'b1111, 0, -1);
    step(0, 0, 4'b0100, 0, -1);
    step(0, 0, 4'b0100, 1, 0);
    step(0, 0, 4'b0000, 0, -1);

    step(0, 1, 4'b0000, 0, -1);
    step(0, 0, 4'b0010, 1, -1);
    step(0, 0, 4'b0000, 0, -1);

    repeat (4) step(0, 0, 4'b1111, 0, -1);
    step(0, 1, 4'b0001, 1, -1);
    step(0, 0, 4'b0000, 0, -1);

    for (int c = 0; c < 600; c++)
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 29) == 0),
           NREQ'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), -1);

    repeat (DEPTH + 1) step(0, 0, 4'b0000, 1, -1);
    step(0, 0, 4'b0000, 0, -1);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_pq_ctrl.md
SR_PQ_CTRL -- requirements
Module: sr_pq_ctrl

Interface
REQ-001 Parameter: DEPTH, 8, number of stages in the attached shift-register PQ array (>=2).
REQ-002 Parameter: NREQ, 4, number of enqueue requesters (>=2).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  synchronous clear of the queue contents.
REQ-006 enq_valid  input  NREQ  per-requester enqueue request.
REQ-007 enq_kv  input  NREQ x kv_t  per-requester key-value to insert.
REQ-008 enq_ready  output  NREQ  one-hot grant; a transfer occurs on requester i when enq_valid[i] and enq_ready[i] are both 1.
REQ-009 deq_valid  output  1  head entry available (count != 0).
REQ-010 deq_ready  input  1  consumer accepts the head entry.
REQ-011 deq_kv  output  kv_t  current head, taken from stage 1 of the array.
REQ-012 pq_head  input  kv_t  stage-1 stored key-value from the array.
REQ-013 pq_rst, pq_enq, pq_deq, pq_replace  output  1 each  array control strobes.
REQ-014 pq_kvi  output  kv_t  global key-value input to the array.
REQ-015 count  output  clog2(DEPTH+1)  number of valid entries.
REQ-016 full, empty  output  1 each  count==DEPTH, count==0.

Function
REQ-017 Requesters with enq_valid set SHALL be arbitrated round-robin; the search starts at pointer rr_ptr and wraps from NREQ-1 to 0.
REQ-018 enq_ready SHALL be combinational and one-hot or zero, asserted only for the winning requester.
REQ-019 A grant SHALL be allowed only when count<DEPTH, or when count==DEPTH and a dequeue transfer occurs in the same cycle.
REQ-020 rr_ptr SHALL advance to (grantee+1) mod NREQ after each enqueue transfer and SHALL hold otherwise.
REQ-021 deq_valid SHALL equal !empty, and deq_kv SHALL equal pq_head in the same cycle, with no added latency.
REQ-022 Enqueue transfer only: pq_enq=1 and pq_kvi=granted enq_kv, and count increments at the next edge.
REQ-023 Dequeue transfer only (deq_valid & deq_ready): pq_deq=1 and count decrements at the next edge.
REQ-024 Both transfers in one cycle: pq_replace=1, pq_enq=0, pq_deq=0, pq_kvi=granted kv, and count is unchanged.
  - The consumer receives the pre-edge head even if the inserted key is smaller; this is the array's defined replace semantics.
REQ-025 deq_ready while empty SHALL be ignored: no strobe, count unchanged.
  - Enqueue on an empty queue SHALL be a plain enq even when deq_ready=1.
REQ-026 At most one of pq_enq, pq_deq, pq_replace SHALL be 1 in any cycle.
  - All three SHALL be 0 when no transfer occurs.
  - pq_kvi SHALL be KV_EMPTY when no enqueue is granted.
REQ-027 flush=1 SHALL force the following, overriding all requests:
  - pq_rst=1 combinationally;
  - enq_ready=0 and all array strobes 0;
  - count=0 at the next edge;
  - rr_ptr unchanged.
REQ-028 The count update SHALL be registered; full and empty SHALL be derived combinationally from the registered count.
REQ-029 count SHALL never exceed DEPTH or go below 0.
  - Any violation detected in simulation SHALL raise an assertion error.

Reset
REQ-030 While rst=1:
  - pq_rst=1;
  - count=0, rr_ptr=0;
  - enq_ready=0, all other strobes 0, pq_kvi=KV_EMPTY;
  - deq_valid=0, empty=1, full=0.
REQ-031 Reset SHALL take priority over flush and over all requests.
  - A reset asserted mid-operation SHALL discard any transfer in that cycle.

Verification
REQ-032 After reset, enq_valid=4'b1111 held for 4 cycles SHALL produce grants to requesters 0,1,2,3 in order, after which count=4.
REQ-033 Enqueue keys 5,3,9 from requester 0 (DEPTH=8), then deq_ready=1 for 3 cycles SHALL yield deq_kv keys 3,5,9, with count stepping 3,2,1,0 and empty=1 at the end.
REQ-034 Fill to count=8 (full=1), then enq_valid[2]=1 with deq_ready=0 SHALL give enq_ready=0; adding deq_ready=1 SHALL give pq_replace=1 and count staying 8.
REQ-035 With count=0, enq_valid[1]=1 and deq_ready=1 in the same cycle SHALL give pq_enq=1, pq_replace=0, and count=1.
REQ-036 With count=5, asserting flush together with enq_valid=4'b0001 and deq_ready=1 SHALL give pq_rst=1 and no strobes, then count=0 and deq_valid=0 on the next cycle.
